// File: rtl/cpu_ctrl_seq.sv
// Multi-cycle control sequencer: owns pc/ir and steps FETCH/DECODE/EXEC/MEM/WB.
// Optional CTRL_ILLEGAL_TRAP_EN: illegal opcodes halt and set a sticky flag.
module cpu_ctrl_seq #(
    parameter int PC_W    = 12,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               alu_zero,
    input  logic               mem_ready,
    output logic [PC_W-1:0]    imem_addr,
    output logic [3:0]         alu_op,
    output logic [2:0]         sel_a,
    output logic [2:0]         sel_b,
    output logic [7:0]         gr_latch,
    output logic               wb_from_mem,
    output logic               dmem_re,
    output logic               dmem_we,
    output logic               busy,
    output logic               halted,
    output logic               illegal
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               zflag_q, zflag_d;

    logic [3:0]      opc;
    logic [PC_W-1:0] tgt;
    logic            is_alu, is_ld, is_st, is_jmp, is_bz, is_hlt;
    logic            unused_ir;

    assign opc       = ir_q[15:12];
    assign tgt       = PC_W'(ir_q[11:0]);
    assign is_alu    = ~opc[3];
    assign is_ld     = (opc == 4'h8);
    assign is_st     = (opc == 4'h9);
    assign is_jmp    = (opc == 4'hA);
    assign is_bz     = (opc == 4'hB);
    assign is_hlt    = (opc == 4'hF);
    assign unused_ir = ^ir_q[2:0];

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic ill_q, ill_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            zflag_q <= 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
            ill_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            zflag_q <= zflag_d;
`ifdef CTRL_ILLEGAL_TRAP_EN
            ill_q   <= ill_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        zflag_d = zflag_q;
`ifdef CTRL_ILLEGAL_TRAP_EN
        ill_d   = ill_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                ir_d    = imem_rdata;
                pc_d    = pc_q + PC_W'(1);
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (is_alu || is_jmp || is_bz) begin
                    state_d = S_EXEC;
                end else if (is_ld || is_st) begin
                    state_d = S_MEM;
                end else if (is_hlt) begin
                    state_d = S_HALT;
                end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                    state_d = S_HALT;
                    ill_d   = 1'b1;
`else
                    state_d = S_FETCH;
`endif
                end
            end
            S_EXEC: begin
                if (is_alu) begin
                    zflag_d = alu_zero;
                    state_d = S_WB;
                end else begin
                    // Branches leave zflag alone so BZ chains test the same ALU result.
                    if (is_jmp || (is_bz && zflag_q)) pc_d = tgt;
                    state_d = S_FETCH;
                end
            end
            S_MEM: begin
                if (mem_ready) state_d = is_ld ? S_WB : S_FETCH;
            end
            S_WB: begin
                state_d = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        imem_addr   = pc_q;
        alu_op      = 4'h0;
        sel_a       = ir_q[8:6];
        sel_b       = ir_q[5:3];
        gr_latch    = 8'h00;
        wb_from_mem = 1'b0;
        dmem_re     = 1'b0;
        dmem_we     = 1'b0;
        busy        = (state_q != S_IDLE) && (state_q != S_HALT);
        halted      = (state_q == S_HALT);
        if ((state_q == S_EXEC || state_q == S_WB) && is_alu) begin
            alu_op = {1'b0, opc[2:0]};
        end
        if (state_q == S_MEM) begin
            dmem_re = is_ld;
            dmem_we = is_st;
        end
        if (state_q == S_WB) begin
            gr_latch    = 8'h01 << ir_q[11:9];
            wb_from_mem = is_ld;
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    assign illegal = ill_q;
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Bench for cpu_ctrl_seq: directed programs plus a random program, checked
// against an instruction-level model of pc/zflag and per-opcode cycle shape.
module tb_cpu_ctrl_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] imem_rdata;
    logic        alu_zero;
    logic        mem_ready;
    logic [11:0] imem_addr;
    logic [3:0]  alu_op;
    logic [2:0]  sel_a;
    logic [2:0]  sel_b;
    logic [7:0]  gr_latch;
    logic        wb_from_mem;
    logic        dmem_re;
    logic        dmem_we;
    logic        busy;
    logic        halted;
    logic        illegal;

    logic [15:0] imem [4096];
    logic [11:0] mpc;
    logic        mz;
    logic        mhalt;
    int          checks;
    int          failures;

    cpu_ctrl_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .imem_rdata(imem_rdata),
        .alu_zero(alu_zero), .mem_ready(mem_ready), .imem_addr(imem_addr),
        .alu_op(alu_op), .sel_a(sel_a), .sel_b(sel_b), .gr_latch(gr_latch),
        .wb_from_mem(wb_from_mem), .dmem_re(dmem_re), .dmem_we(dmem_we),
        .busy(busy), .halted(halted), .illegal(illegal)
    );

    assign imem_rdata = imem[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        alu_zero  = 1'($urandom);
        mem_ready = 1'($urandom);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        #7;
        @(negedge clk);
        rst_n = 1'b1;
        mpc   = 12'h000;
        mz    = 1'b0;
        mhalt = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic strobes_idle(input string tag);
        chk({tag, "_lat"}, gr_latch, 0);
        chk({tag, "_re"}, dmem_re, 0);
        chk({tag, "_we"}, dmem_we, 0);
    endtask

    // One instruction from the model's pc; DUT is expected to be in its fetch cycle.
    task automatic exec_one(input int nw = -1, input int zf = -1);
        logic [15:0] ins;
        logic [3:0]  op;
        logic [11:0] npc;
        int          n;
        if (mhalt) return;
        ins = imem[mpc];
        op  = ins[15:12];
        npc = mpc + 12'h001;
        chk("f_busy", busy, 1);
        chk("f_pc", imem_addr, mpc);
        strobes_idle("f");
        tick();
        chk("d_pc", imem_addr, npc);
        chk("d_sela", sel_a, ins[8:6]);
        chk("d_selb", sel_b, ins[5:3]);
        strobes_idle("d");
        if (op < 4'h8) begin
            tick();
            chk("x_aluop", alu_op, {1'b0, op[2:0]});
            strobes_idle("x");
            alu_zero = (zf < 0) ? 1'($urandom) : 1'(zf);
            mz       = alu_zero;
            tick();
            chk("w_lat", gr_latch, 8'h01 << ins[11:9]);
            chk("w_mem", wb_from_mem, 0);
            chk("w_aluop", alu_op, {1'b0, op[2:0]});
            chk("w_sela", sel_a, ins[8:6]);
            tick();
        end else if (op == 4'h8 || op == 4'h9) begin
            tick();
            n = (nw < 0) ? int'($urandom_range(0, 3)) : nw;
            for (int i = 0; i <= n; i++) begin
                chk("m_re", dmem_re, op == 4'h8);
                chk("m_we", dmem_we, op == 4'h9);
                chk("m_lat", gr_latch, 0);
                mem_ready = (i == n);
                tick();
            end
            if (op == 4'h8) begin
                chk("l_lat", gr_latch, 8'h01 << ins[11:9]);
                chk("l_mem", wb_from_mem, 1);
                chk("l_re", dmem_re, 0);
                tick();
            end
        end else if (op == 4'hA || op == 4'hB) begin
            tick();
            strobes_idle("b");
            if (op == 4'hA || mz) npc = ins[11:0];
            tick();
        end else if (op == 4'hF) begin
            tick();
            chk("h_halt", halted, 1);
            chk("h_busy", busy, 0);
            mhalt = 1'b1;
        end else begin
            tick();
`ifdef CTRL_ILLEGAL_TRAP_EN
            chk("i_halt", halted, 1);
            chk("i_ill", illegal, 1);
            mhalt = 1'b1;
`else
            chk("i_ill", illegal, 0);
`endif
        end
        mpc = npc;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        alu_zero  = 1'b0;
        mem_ready = 1'b0;
        for (int i = 0; i < 4096; i++) imem[i] = 16'h0000;

        do_reset();
        chk("rst_busy", busy, 0);
        chk("rst_halt", halted, 0);
        chk("rst_pc", imem_addr, 0);
        chk("rst_aluop", alu_op, 0);
        chk("rst_sela", sel_a, 0);
        chk("rst_selb", sel_b, 0);
        chk("rst_wbm", wb_from_mem, 0);
        chk("rst_ill", illegal, 0);
        strobes_idle("rst");
        tick();
        chk("idle_hold", busy, 0);

        imem[12'h000] = 16'h0212;
        imem[12'h001] = 16'h8A40;
        imem[12'h002] = 16'h1000;
        imem[12'h003] = 16'hB010;
        imem[12'h010] = 16'h2000;
        imem[12'h011] = 16'hB020;
        imem[12'h012] = 16'hAFFF;
        imem[12'hFFF] = 16'h3000;
        go();
        exec_one();
        exec_one(3);
        exec_one(-1, 1);
        exec_one();
        chk("bz_taken", mpc, 12'h010);
        exec_one(-1, 0);
        exec_one();
        chk("bz_not", mpc, 12'h012);
        exec_one();
        exec_one();
        chk("wrap", mpc, 12'h000);
        exec_one();

        do_reset();
        imem[12'h000] = 16'h0000;
        imem[12'h001] = 16'h4000;
        imem[12'h002] = 16'h9000;
        imem[12'h003] = 16'hF000;
        go();
        for (int i = 0; i < 4; i++) exec_one();
        for (int i = 0; i < 6; i++) begin
            start = i[0];
            tick();
            chk("halt_stay", halted, 1);
            chk("halt_busy", busy, 0);
            strobes_idle("halt");
        end
        start = 1'b0;

        do_reset();
        imem[12'h000] = 16'hC000;
        imem[12'h001] = 16'h0E00;
        go();
        exec_one();
`ifndef CTRL_ILLEGAL_TRAP_EN
        chk("nop_pc", mpc, 12'h001);
        exec_one();
`endif

        do_reset();
        imem[12'h000] = 16'h9000;
        go();
        tick();
        tick();
        mem_ready = 1'b0;
        chk("abort_we_pre", dmem_we, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_we", dmem_we, 0);
        chk("abort_busy", busy, 0);
        chk("abort_pc", imem_addr, 0);
        tick();
        strobes_idle("abort");

        do_reset();
        for (int i = 0; i < 4096; i++) begin
            imem[i] = {4'($urandom_range(0, 11)), 12'($urandom)};
        end
        go();
        for (int k = 0; k < 400; k++) exec_one();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
